descriptor_exec: RTL and testbench
==================================

Name: descriptor_exec

Overview:
- Consumes 128-bit descriptors from the descriptor FIFO, which is filled by the descriptor-fetch stage.
- Splits each descriptor's transfer into bus bursts of at most MAX_BURST dwords and issues them to the bus interface with a req/ack/done handshake.
- Reports per-descriptor completion, interrupts and malformed descriptors to the DMA control/status logic.

Parameters:
MAX_BURST, 16, maximum dwords per bus burst; legal range 1..255.
CNT_W, 24, width of the transfer-count field taken from dword1[CNT_W-1:0].

Ports:
clk  in  1  system clock; all logic on rising edge
rstb  in  1  reset, synchronous, active-low
descpfifo_empty  in  1  descriptor FIFO empty
descpfifo_rden  out  1  FIFO pop; rdata valid the following cycle
descpfifo_rdata  in  128  {dword3,dword2,dword1,dword0}
dma_abort  in  1  synchronous abort request from software
xfer_req  out  1  burst request to bus interface
xfer_addr  out  32  burst byte start address
xfer_len  out  8  burst length in dwords
xfer_ack  in  1  bus interface accepted request
xfer_done  in  1  one-cycle pulse: current burst finished
dma_busy  out  1  high whenever state != IDLE
desc_done  out  1  one-cycle pulse per completed descriptor
dma_irq  out  1  one-cycle pulse with desc_done when dword2[2]=1
desc_err  out  1  one-cycle pulse: popped descriptor had valid bit dword2[1]=0

Behaviour:
- Reset (rstb=0 at a clk edge): state=IDLE. xfer_req, xfer_addr, xfer_len, desc_done, dma_irq and desc_err all 0. Internal addr, remaining and ctrl registers cleared. Applies mid-burst; any outstanding burst is abandoned.
- descpfifo_rden is combinational: IDLE & !descpfifo_empty & !dma_abort. Exactly one pop per descriptor.
- IDLE -> LOAD when rden=1.
- LOAD: capture cur_addr=dword0, remaining=dword1[CNT_W-1:0], ctrl=dword2.
  - dword2[1]=0 -> desc_err pulse next cycle, go IDLE. Link bit dword2[0] is ignored here; linking is handled by the fetch stage.
  - remaining=0 -> COMPLETE.
  - else -> REQ.
- REQ: xfer_req=1. xfer_addr=cur_addr. xfer_len=min(remaining,MAX_BURST), zero-extended to 8 bits. All three held stable until xfer_ack is sampled 1; then go WAIT_DONE, and xfer_req drops the next cycle. xfer_done is ignored in REQ.
- WAIT_DONE: on xfer_done:
  - cur_addr += xfer_len*4, modulo 2^32; wrap is silent.
  - remaining -= xfer_len.
  - Go COMPLETE if the new remaining=0, else REQ.
  - xfer_ack is ignored in WAIT_DONE.
- COMPLETE: desc_done=1 for one cycle; dma_irq=ctrl[2] in the same cycle; -> IDLE. Back-to-back descriptors: the next pop may occur in the cycle after COMPLETE.
- Latency: empty falls at cycle 0 -> rden in cycle 0, LOAD in cycle 1, xfer_req high in cycle 2.
- dma_abort:
  - In IDLE: blocks pops.
  - In LOAD, REQ or COMPLETE: go IDLE next cycle with no desc_done/irq; xfer_req drops.
  - In WAIT_DONE: wait for xfer_done, then go IDLE with no done pulse.
  - Abort has priority over xfer_ack in the same cycle (request withdrawn).
- The final burst of a descriptor may be shorter than MAX_BURST. Bursts never span descriptors.

Test Plan:
- Single descriptor {d0=0x1000_0000, d1=40, d2=0x6}, MAX_BURST=16 -> bursts (0x1000_0000,16), (0x1000_0040,16), (0x1000_0080,8); then desc_done and dma_irq pulse together, 1 cycle each.
- Count=0, d2=0x2 -> no xfer_req; desc_done 2 cycles after rden; dma_irq=0.
- d2=0x1 (valid bit clear) -> desc_err pulse, no xfer_req, return to IDLE; a following valid descriptor then executes normally.
- d0=0xFFFF_FFF8, d1=4 -> bursts (0xFFFF_FFF8,4), and after xfer_done the internal addr reads 0x0000_0008; desc_done fires.
- xfer_ack delayed 5 cycles -> xfer_req/addr/len stable all 5 cycles. Spurious xfer_done in REQ -> ignored. dma_abort during WAIT_DONE -> IDLE only after xfer_done, no desc_done.
- Two descriptors queued back-to-back -> two pops, second rden one cycle after first desc_done. Assert rstb=0 mid-REQ -> outputs 0 next edge, no pop until rstb=1.

Source files
------------

// File: rtl/descriptor_exec.sv
// Descriptor execution engine: pops 128-bit DMA descriptors, splits each transfer
// into bus bursts of at most MAX_BURST dwords and reports completion/errors.
module descriptor_exec #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 24
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         descpfifo_empty,
  output logic         descpfifo_rden,
  input  logic [127:0] descpfifo_rdata,
  input  logic         dma_abort,
  output logic         xfer_req,
  output logic [31:0]  xfer_addr,
  output logic [7:0]   xfer_len,
  input  logic         xfer_ack,
  input  logic         xfer_done,
  output logic         dma_busy,
  output logic         desc_done,
  output logic         dma_irq,
  output logic         desc_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    WAIT_DONE,
    COMPLETE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [7:0]       MAX_LEN = 8'(MAX_BURST);

  state_t           state, state_nxt;
  logic [31:0]      cur_addr;
  logic [CNT_W-1:0] remaining;
  logic             ctrl_irq;
  logic             err_q;
  logic             abort_pend;
  logic [7:0]       burst_len;

  logic [31:0]      ld_addr;
  logic [CNT_W-1:0] ld_cnt;
  logic             ld_valid;
  logic             ld_irq;
  logic             unused_rdata;

  assign ld_addr      = descpfifo_rdata[31:0];
  assign ld_cnt       = descpfifo_rdata[32 +: CNT_W];
  assign ld_valid     = descpfifo_rdata[65];
  assign ld_irq       = descpfifo_rdata[66];
  assign unused_rdata = ^descpfifo_rdata;

  assign burst_len = (remaining > MAX_CNT) ? MAX_LEN : remaining[7:0];

  // Address and length track the working registers, so they sit at zero out of reset
  // and stay frozen while a request waits for its acknowledge.
  assign xfer_addr = cur_addr;
  assign xfer_len  = burst_len;
  assign desc_err  = err_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_nxt      = state;
    descpfifo_rden = 1'b0;
    xfer_req       = 1'b0;
    desc_done      = 1'b0;
    dma_irq        = 1'b0;
    dma_busy       = (state != IDLE);

    unique case (state)
      IDLE: begin
        descpfifo_rden = rstb && !descpfifo_empty && !dma_abort;
        if (descpfifo_rden) state_nxt = LOAD;
      end
      LOAD: begin
        if (dma_abort || !ld_valid) state_nxt = IDLE;
        else if (ld_cnt == '0)      state_nxt = COMPLETE;
        else                        state_nxt = REQ;
      end
      REQ: begin
        xfer_req = 1'b1;
        // Abort wins over a same-cycle acknowledge: the request is withdrawn.
        if (dma_abort)     state_nxt = IDLE;
        else if (xfer_ack) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (xfer_done) begin
          if (abort_pend || dma_abort)             state_nxt = IDLE;
          else if (remaining == CNT_W'(burst_len)) state_nxt = COMPLETE;
          else                                     state_nxt = REQ;
        end
      end
      COMPLETE: begin
        desc_done = !dma_abort;
        dma_irq   = !dma_abort && ctrl_irq;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cur_addr   <= '0;
      remaining  <= '0;
      ctrl_irq   <= 1'b0;
      err_q      <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      err_q <= (state == LOAD) && !ld_valid;
      // An abort seen while a burst is in flight is remembered until its done pulse.
      abort_pend <= (state == WAIT_DONE) && !xfer_done && (abort_pend || dma_abort);

      if (state == LOAD) begin
        cur_addr  <= ld_addr;
        remaining <= ld_cnt;
        ctrl_irq  <= ld_irq;
      end else if (state == WAIT_DONE && xfer_done) begin
        cur_addr  <= cur_addr + {22'b0, burst_len, 2'b00};
        remaining <= remaining - CNT_W'(burst_len);
      end
    end
  end

endmodule

// File: tb/tb_descriptor_exec.sv
// Scoreboard bench for descriptor_exec: a reference model expands each queued
// descriptor into expected bursts/done/err events; a monitor pops and compares.
`timescale 1ns/1ps
module tb_descriptor_exec;

  localparam int MAX_BURST = 16;
  localparam int CNT_W     = 24;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         descpfifo_empty = 1'b1;
  logic         descpfifo_rden;
  logic [127:0] descpfifo_rdata = '0;
  logic         dma_abort = 1'b0;
  logic         xfer_req;
  logic [31:0]  xfer_addr;
  logic [7:0]   xfer_len;
  logic         xfer_ack = 1'b0;
  logic         xfer_done = 1'b0;
  logic         dma_busy;
  logic         desc_done;
  logic         dma_irq;
  logic         desc_err;

  descriptor_exec #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rstb            (rstb),
    .descpfifo_empty (descpfifo_empty),
    .descpfifo_rden  (descpfifo_rden),
    .descpfifo_rdata (descpfifo_rdata),
    .dma_abort       (dma_abort),
    .xfer_req        (xfer_req),
    .xfer_addr       (xfer_addr),
    .xfer_len        (xfer_len),
    .xfer_ack        (xfer_ack),
    .xfer_done       (xfer_done),
    .dma_busy        (dma_busy),
    .desc_done       (desc_done),
    .dma_irq         (dma_irq),
    .desc_err        (desc_err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_BURST = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        irq;
  } ev_t;

  ev_t          exp_q[$];
  logic [127:0] fifo_q[$];

  int n_pass = 0, n_checks = 0;
  int n_pushed = 0, n_popped = 0, n_bursts = 0;
  int cyc = 0, rden_cyc = -1, done_cyc = -1, prev_done_cyc = -1, req_cyc = -1;
  bit pop_seen = 1'b0, abort_last = 1'b0, hold_ack = 1'b0;
  int ack_force = -1, done_force = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a descriptor is a list of bursts walking the address upward.
  function automatic void model_desc(input logic [31:0] addr0, input int cnt, input logic [31:0] d2);
    ev_t         e;
    int          rem;
    int          len;
    logic [31:0] addr;
    rem  = cnt;
    addr = addr0;
    e    = '{EV_ERR, 32'h0, 8'h0, 1'b0};
    if (!d2[1]) begin
      exp_q.push_back(e);
      return;
    end
    while (rem > 0) begin
      len = (rem > MAX_BURST) ? MAX_BURST : rem;
      e   = '{EV_BURST, addr, 8'(len), 1'b0};
      exp_q.push_back(e);
      addr = addr + 32'(len * 4);
      rem  = rem - len;
    end
    e = '{EV_DONE, 32'h0, 8'h0, d2[2]};
    exp_q.push_back(e);
  endfunction

  task automatic push_desc(input logic [31:0] a, input int cnt, input logic [31:0] d2, input bit model);
    logic [31:0] d1;
    d1 = {8'($urandom), 24'(cnt)};
    fifo_q.push_back({$urandom, d2, d1, a});
    n_pushed++;
    if (model) model_desc(a, cnt, d2);
  endtask

  task automatic expect_ev(input ev_kind_t kind, input logic [31:0] addr, input logic [7:0] len,
                           input logic irq);
    ev_t e;
    check("event was expected", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event kind", 64'(int'(kind)), 64'(int'(e.kind)));
      if (kind == EV_BURST && e.kind == EV_BURST) begin
        check("burst addr", 64'(addr), 64'(e.addr));
        check("burst len", 64'(len), 64'(e.len));
      end
      if (kind == EV_DONE && e.kind == EV_DONE) check("dma_irq with desc_done", 64'(irq), 64'(e.irq));
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    pop_seen   = descpfifo_rden;
    abort_last = dma_abort;
    if (rstb) begin
      if (descpfifo_rden) rden_cyc = cyc;
      if (xfer_req && req_cyc < rden_cyc) req_cyc = cyc;
      if (xfer_req && xfer_ack && !dma_abort) begin
        n_bursts++;
        expect_ev(EV_BURST, xfer_addr, xfer_len, 1'b0);
      end
      if (desc_done) begin
        prev_done_cyc = done_cyc;
        done_cyc      = cyc;
        expect_ev(EV_DONE, 32'h0, 8'h0, dma_irq);
      end
      if (desc_err) expect_ev(EV_ERR, 32'h0, 8'h0, 1'b0);
      if (dma_irq && !desc_done) check("dma_irq only with desc_done", 64'(dma_irq), 64'd0);
    end
  end

  // Descriptor FIFO: rdata becomes valid the cycle after a pop.
  always begin
    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() > 0) begin
      descpfifo_rdata = fifo_q.pop_front();
      n_popped++;
    end
    descpfifo_empty = (fifo_q.size() == 0);
  end

  // Bus responder: random ack/done latency, spurious done pulses while requesting.
  int          phase = 0, rcnt = 0;
  logic [31:0] hold_addr = '0;
  logic [7:0]  hold_len = '0;
  always begin
    @(posedge clk);
    #1;
    xfer_ack  = 1'b0;
    xfer_done = 1'b0;
    if (!rstb) phase = 0;
    else begin
      case (phase)
        0: if (xfer_req) begin
             hold_addr = xfer_addr;
             hold_len  = xfer_len;
             rcnt      = (ack_force >= 0) ? ack_force : int'($urandom_range(0, 5));
             if (rcnt == 0 && !hold_ack) begin
               xfer_ack = 1'b1;
               phase    = 2;
             end else phase = 1;
           end
        1: if (!xfer_req) begin
             check("xfer_req held until ack or abort", 64'(abort_last), 64'd1);
             phase = 0;
           end else begin
             check("xfer_addr stable while waiting", 64'(xfer_addr), 64'(hold_addr));
             check("xfer_len stable while waiting", 64'(xfer_len), 64'(hold_len));
             if (!hold_ack) rcnt--;
             if (!hold_ack && rcnt <= 0) begin
               xfer_ack = 1'b1;
               phase    = 2;
             end else if ($urandom_range(0, 3) == 0) xfer_done = 1'b1;
           end
        2: begin
             rcnt = (done_force >= 0) ? done_force : int'($urandom_range(0, 3));
             if (rcnt == 0) begin
               xfer_done = 1'b1;
               phase     = 0;
             end else phase = 3;
           end
        default: begin
             rcnt--;
             if (rcnt <= 0) begin
               xfer_done = 1'b1;
               phase     = 0;
             end
           end
      endcase
    end
  end

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !dma_busy && descpfifo_empty) break;
    end
    check("all expected events drained", 64'(exp_q.size()), 64'd0);
    check("engine idle after drain", 64'(dma_busy), 64'd0);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !xfer_req; i++) tick(1);
    check("xfer_req raised", 64'(xfer_req), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0;
    ev_t e;

    // Reset state.
    tick(3);
    @(negedge clk);
    check("reset xfer_req", 64'(xfer_req), 64'd0);
    check("reset xfer_addr", 64'(xfer_addr), 64'd0);
    check("reset xfer_len", 64'(xfer_len), 64'd0);
    check("reset dma_busy", 64'(dma_busy), 64'd0);
    check("reset desc_done/irq/err", 64'({desc_done, dma_irq, desc_err}), 64'd0);
    tick(1);
    rstb = 1'b1;
    tick(2);

    // Three-burst descriptor with a slow acknowledge.
    ack_force = 5;
    push_desc(32'h1000_0000, 40, 32'h6, 1'b1);
    wait_idle(400);
    check("rden to xfer_req latency", 64'(req_cyc - rden_cyc), 64'd2);
    ack_force = -1;

    // Zero-count descriptor completes without any request.
    push_desc(32'h1234_5678, 0, 32'h2, 1'b1);
    wait_idle(100);
    check("zero count rden to desc_done", 64'(done_cyc - rden_cyc), 64'd2);

    // Malformed descriptor followed by a valid one.
    push_desc(32'h2000_0000, 12, 32'h1, 1'b1);
    push_desc(32'h2000_0100, 20, 32'h2, 1'b1);
    wait_idle(300);

    // Address wrap at 2^32.
    push_desc(32'hFFFF_FFF8, 4, 32'h2, 1'b1);
    wait_idle(100);
    check("internal address after wrap", 64'(dut.cur_addr), 64'h0000_0008);
    push_desc(32'hFFFF_FFF0, 20, 32'h6, 1'b1);
    wait_idle(200);

    // Abort during WAIT_DONE: engine waits for done, then idles with no completion.
    done_force = 3;
    push_desc(32'h3000_0000, 40, 32'h6, 1'b0);
    e = '{EV_BURST, 32'h3000_0000, 8'd16, 1'b0};
    exp_q.push_back(e);
    b0 = n_bursts;
    for (int i = 0; i < 100 && n_bursts == b0; i++) tick(1);
    check("first burst accepted before abort", 64'(n_bursts - b0), 64'd1);
    dma_abort = 1'b1;
    push_desc(32'h4000_0000, 8, 32'h2, 1'b0);
    tick(10);
    check("abort in WAIT_DONE returns to idle", 64'(dma_busy), 64'd0);
    check("abort blocks pops in idle", 64'(n_popped), 64'(n_pushed - 1));
    model_desc(32'h4000_0000, 8, 32'h2);
    dma_abort  = 1'b0;
    done_force = -1;
    wait_idle(200);

    // Abort while requesting withdraws the request.
    hold_ack = 1'b1;
    push_desc(32'h5000_0000, 8, 32'h2, 1'b0);
    wait_req(50);
    dma_abort = 1'b1;
    tick(1);
    dma_abort = 1'b0;
    hold_ack  = 1'b0;
    tick(2);
    check("abort in REQ drops xfer_req", 64'(xfer_req), 64'd0);
    check("abort in REQ returns to idle", 64'(dma_busy), 64'd0);

    // Back-to-back descriptors.
    push_desc(32'h0, 0, 32'h6, 1'b1);
    push_desc(32'h0, 0, 32'h2, 1'b1);
    wait_idle(100);
    check("second pop one cycle after first done", 64'(rden_cyc), 64'(prev_done_cyc + 1));

    // Reset in the middle of a request.
    hold_ack = 1'b1;
    push_desc(32'h6000_0000, 8, 32'h2, 1'b0);
    push_desc(32'h7000_0000, 24, 32'h6, 1'b0);
    wait_req(50);
    b0   = n_popped;
    rstb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset mid-REQ xfer_req", 64'(xfer_req), 64'd0);
    check("reset mid-REQ xfer_addr/len", 64'({xfer_addr, xfer_len}), 64'd0);
    check("reset mid-REQ dma_busy", 64'(dma_busy), 64'd0);
    tick(3);
    check("no pop while in reset", 64'(n_popped), 64'(b0));
    hold_ack = 1'b0;
    model_desc(32'h7000_0000, 24, 32'h6);
    rstb = 1'b1;
    wait_idle(300);

    // Randomized descriptor stream.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] d2;
      d2 = {29'($urandom), ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, 1'($urandom)};
      push_desc($urandom, int'($urandom_range(0, 70)), d2, 1'b1);
      tick(int'($urandom_range(0, 3)));
    end
    wait_idle(20000);
    check("one pop per descriptor", 64'(n_popped), 64'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
